// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing a single AES-256 core between two requesters.
// state | meaning
// IDLE  | core free, waiting to accept a request
// ISSUE | aes_start pulse, wait counter cleared
// WAIT  | waiting for aes_done or timeout
// RESP  | result held on granted port until ack
module aes_core_arbiter #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [127:0] req0_data,
  output logic         req0_ready,
  output logic         rsp0_valid,
  output logic [127:0] rsp0_data,
  input  logic         rsp0_ack,
  input  logic         req1_valid,
  input  logic [127:0] req1_data,
  output logic         req1_ready,
  output logic         rsp1_valid,
  output logic [127:0] rsp1_data,
  input  logic         rsp1_ack,
  output logic         aes_start,
  output logic [127:0] aes_in,
  input  logic [127:0] aes_out,
  input  logic         aes_done,
  input  logic         aes_busy,
  output logic         grant_id,
  output logic         busy,
  output logic         timeout_err
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          last_grant;
  logic [CW-1:0] wait_cnt;
  logic          pick0, pick1, accept_ok;

  // When both are valid, the requester that was not served last wins.
  always_comb begin
    pick0     = req0_valid && (!req1_valid || last_grant);
    pick1     = req1_valid && (!req0_valid || !last_grant);
    accept_ok = (state == IDLE) && !aes_busy;
  end

  assign req0_ready = accept_ok && pick0;
  assign req1_ready = accept_ok && pick1;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      aes_start   <= 1'b0;
      aes_in      <= '0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_data   <= '0;
      rsp1_data   <= '0;
      grant_id    <= 1'b0;
      timeout_err <= 1'b0;
      last_grant  <= 1'b1;
      wait_cnt    <= '0;
    end else begin
      aes_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            aes_in    <= req1_ready ? req1_data : req0_data;
            grant_id  <= req1_ready;
            aes_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (aes_done) begin
            if (grant_id) begin
              rsp1_data  <= aes_out;
              rsp1_valid <= 1'b1;
            end else begin
              rsp0_data  <= aes_out;
              rsp0_valid <= 1'b1;
            end
            state <= RESP;
          end else if (wait_cnt == CNT_MAX) begin
            // Abort with no response; last_grant is left as it was.
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (grant_id ? rsp1_ack : rsp0_ack) begin
            last_grant <= grant_id;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter with a fixed-latency core model (result = block ^ AA..AA).
module tb_aes_core_arbiter;

  localparam logic [127:0] MASK = {16{8'hAA}};
  localparam logic [127:0] D0   = {4{32'h01234567}};
  localparam logic [127:0] D1   = {4{32'h89ABCDEF}};
  localparam logic [127:0] D2   = {4{32'hDEADBEEF}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [127:0] req0_data = '0, req1_data = '0;
  logic         req0_ready, req1_ready;
  logic         rsp0_valid, rsp1_valid;
  logic [127:0] rsp0_data, rsp1_data;
  logic         rsp0_ack = 1'b0, rsp1_ack = 1'b0;
  logic         aes_start;
  logic [127:0] aes_in;
  logic [127:0] aes_out = '0;
  logic         aes_done = 1'b0;
  logic         aes_busy = 1'b0;
  logic         grant_id, busy, timeout_err;

  int tests = 0;
  int fails = 0;

  int           core_lat = 14;
  bit           core_en  = 1'b1;
  int           cd       = 0;
  logic [127:0] core_val = '0;
  int           start_cnt = 0;

  aes_core_arbiter #(.TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ack(rsp0_ack),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ack(rsp1_ack),
    .aes_start(aes_start), .aes_in(aes_in), .aes_out(aes_out),
    .aes_done(aes_done), .aes_busy(aes_busy),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Core model: done pulse core_lat cycles after the start cycle.
  always @(negedge clk) begin
    aes_done = 1'b0;
    if (core_en && aes_start === 1'b1) begin
      cd       = core_lat;
      core_val = aes_in ^ MASK;
    end else if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) begin
        aes_done = 1'b1;
        aes_out  = core_val;
      end
    end
  end

  always @(posedge clk) if (aes_start === 1'b1) start_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ack = 1'b0; rsp1_ack = 1'b0; aes_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ready(output int who);
    int n = 0;
    who = -1;
    #1;
    while (who < 0 && n < 100) begin
      if (req0_ready) who = 0;
      else if (req1_ready) who = 1;
      else begin
        @(negedge clk); #1; n++;
      end
    end
    tests++;
    if (who < 0) begin
      fails++;
      $display("FAIL wait_ready: no ready within 100 cycles, expected one");
    end
  endtask

  task automatic wait_rsp(input int port, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk); #1; cyc++;
    end while (!((port == 1) ? rsp1_valid : rsp0_valid) && cyc < 200);
    tests++;
    if (!((port == 1) ? rsp1_valid : rsp0_valid)) begin
      fails++;
      $display("FAIL wait_rsp%0d: rsp_valid not seen within 200 cycles, expected 1", port);
    end
  endtask

  task automatic ack_port(input int port);
    if (port == 1) rsp1_ack = 1'b1; else rsp0_ack = 1'b1;
    @(negedge clk);
    rsp0_ack = 1'b0; rsp1_ack = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    tests++;
    if ({aes_start, rsp0_valid, rsp1_valid, grant_id, busy, timeout_err} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: start,v0,v1,gid,busy,terr=%b expected 000000",
               {aes_start, rsp0_valid, rsp1_valid, grant_id, busy, timeout_err});
    end
    tests++;
    if (aes_in !== 128'h0) begin fails++; $display("FAIL reset_aes_in: got %h expected 0", aes_in); end
    tests++;
    if (rsp0_data !== 128'h0 || rsp1_data !== 128'h0) begin
      fails++; $display("FAIL reset_rsp_data: got %h/%h expected 0/0", rsp0_data, rsp1_data);
    end
    tests++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
    end
  endtask

  task automatic test_single;
    int cyc;
    bit bad;
    @(negedge clk);
    req0_valid = 1'b1; req0_data = '0;
    #1;
    tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      fails++; $display("FAIL single_ready: got %b%b expected 10", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    tests++;
    if (aes_start !== 1'b1 || grant_id !== 1'b0 || busy !== 1'b1 || aes_in !== 128'h0) begin
      fails++; $display("FAIL single_issue: start=%b gid=%b busy=%b aes_in=%h expected 1 0 1 0",
                        aes_start, grant_id, busy, aes_in);
    end
    wait_rsp(0, cyc);
    tests++;
    if (cyc !== 15) begin fails++; $display("FAIL single_latency: got %0d cycles expected 15", cyc); end
    tests++;
    if (rsp0_data !== MASK || rsp1_valid !== 1'b0) begin
      fails++; $display("FAIL single_data: got %h v1=%b expected %h v1=0", rsp0_data, rsp1_valid, MASK);
    end
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      if (rsp0_valid !== 1'b1 || rsp0_data !== MASK || rsp1_valid !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL single_hold: got valid=%b data=%h expected 1 %h", rsp0_valid, rsp0_data, MASK); end
    ack_port(0);
    req1_valid = 1'b1; req1_data = D1;
    #1;
    tests++;
    if (rsp0_valid !== 1'b0 || busy !== 1'b0 || rsp0_data !== MASK) begin
      fails++; $display("FAIL single_ack: valid=%b busy=%b data=%h expected 0 0 %h", rsp0_valid, busy, rsp0_data, MASK);
    end
    tests++;
    if (req1_ready !== 1'b1) begin fails++; $display("FAIL next_accept: got %b expected 1", req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp(1, cyc);
    tests++;
    if (rsp1_data !== (D1 ^ MASK) || rsp0_data !== MASK) begin
      fails++; $display("FAIL single_r1: got %h/%h expected %h/%h", rsp1_data, rsp0_data, D1 ^ MASK, MASK);
    end
    ack_port(1);
  endtask

  task automatic test_contention;
    int who, cyc, s0;
    logic [127:0] got;
    do_reset;
    req0_valid = 1'b1; req0_data = D0;
    req1_valid = 1'b1; req1_data = D1;
    for (int k = 0; k < 4; k++) begin
      s0 = start_cnt;
      wait_ready(who);
      tests++;
      if (who !== (k % 2)) begin fails++; $display("FAIL cont_order%0d: got %0d expected %0d", k, who, k % 2); end
      @(negedge clk); #1;
      tests++;
      if (grant_id !== 1'((k % 2))) begin fails++; $display("FAIL cont_gid%0d: got %b expected %0d", k, grant_id, k % 2); end
      wait_rsp(who, cyc);
      tests++;
      if (start_cnt - s0 !== 1) begin fails++; $display("FAIL cont_starts%0d: got %0d expected 1", k, start_cnt - s0); end
      got = (who == 1) ? rsp1_data : rsp0_data;
      tests++;
      if (got !== (((k % 2) == 1 ? D1 : D0) ^ MASK)) begin
        fails++; $display("FAIL cont_data%0d: got %h expected %h", k, got, ((k % 2) == 1 ? D1 : D0) ^ MASK);
      end
      ack_port(who);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    int who, cyc;
    bit bad_v, bad_rdy, bad_st;
    do_reset;
    req1_valid = 1'b1; req1_data = D1;
    wait_ready(who);
    tests++;
    if (who !== 1) begin fails++; $display("FAIL bp_lone: got %0d expected 1", who); end
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_data = D0;
    wait_rsp(1, cyc);
    bad_v = 1'b0; bad_rdy = 1'b0; bad_st = 1'b0;
    repeat (20) begin
      @(negedge clk);
      rsp0_ack = 1'b1;
      #1;
      if (rsp1_valid !== 1'b1 || rsp1_data !== (D1 ^ MASK)) bad_v = 1'b1;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) bad_rdy = 1'b1;
      if (aes_start !== 1'b0) bad_st = 1'b1;
    end
    rsp0_ack = 1'b0;
    tests++;
    if (bad_v) begin fails++; $display("FAIL bp_hold: valid=%b data=%h expected 1 %h", rsp1_valid, rsp1_data, D1 ^ MASK); end
    tests++;
    if (bad_rdy) begin fails++; $display("FAIL bp_ready: ready asserted during backpressure, expected 0"); end
    tests++;
    if (bad_st) begin fails++; $display("FAIL bp_start: aes_start asserted during backpressure, expected 0"); end
    ack_port(1);
    #1;
    tests++;
    if (rsp1_valid !== 1'b0 || req0_ready !== 1'b1) begin
      fails++; $display("FAIL bp_release: v1=%b r0=%b expected 0 1", rsp1_valid, req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    wait_rsp(0, cyc);
    tests++;
    if (rsp0_data !== (D0 ^ MASK)) begin fails++; $display("FAIL bp_pending: got %h expected %h", rsp0_data, D0 ^ MASK); end
    ack_port(0);
  endtask

  task automatic test_timeout;
    int who, cyc;
    do_reset;
    core_en = 1'b0;
    req0_valid = 1'b1; req0_data = D0;
    wait_ready(who);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (64) @(negedge clk);
    #1;
    tests++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      fails++; $display("FAIL to_early: busy=%b terr=%b expected 1 0", busy, timeout_err);
    end
    @(negedge clk); #1;
    tests++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      fails++; $display("FAIL to_fire: busy=%b terr=%b v0=%b v1=%b expected 0 1 0 0",
                        busy, timeout_err, rsp0_valid, rsp1_valid);
    end
    core_en = 1'b1;
    req0_valid = 1'b1; req0_data = D2;
    req1_valid = 1'b1; req1_data = D1;
    wait_ready(who);
    tests++;
    if (who !== 0) begin fails++; $display("FAIL to_lastgrant: got %0d expected 0", who); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(0, cyc);
    tests++;
    if (rsp0_data !== (D2 ^ MASK)) begin fails++; $display("FAIL to_after: got %h expected %h", rsp0_data, D2 ^ MASK); end
    ack_port(0);
    #1;
    tests++;
    if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
  endtask

  task automatic test_midreset;
    int who, cyc;
    bit bad;
    do_reset;
    req0_valid = 1'b1; req0_data = D0;
    wait_ready(who);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if ({aes_start, busy, grant_id, timeout_err, rsp0_valid, rsp1_valid} !== 6'b0 || aes_in !== 128'h0) begin
      fails++; $display("FAIL mr_reset: start,busy,gid,terr,v0,v1=%b aes_in=%h expected 000000 0",
                        {aes_start, busy, grant_id, timeout_err, rsp0_valid, rsp1_valid}, aes_in);
    end
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk); #1;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0 ||
          rsp0_data !== 128'h0) bad = 1'b1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL mr_stray_done: v0=%b busy=%b data=%h expected 0 0 0", rsp0_valid, busy, rsp0_data); end
    req0_valid = 1'b1; req0_data = D0;
    req1_valid = 1'b1; req1_data = D1;
    wait_ready(who);
    tests++;
    if (who !== 0) begin fails++; $display("FAIL mr_winner: got %0d expected 0", who); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(0, cyc);
    ack_port(0);
  endtask

  task automatic test_aes_busy;
    int cyc;
    bit bad;
    aes_busy = 1'b1;
    req0_valid = 1'b1; req0_data = D0;
    req1_valid = 1'b1; req1_data = D1;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk); #1;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL busy_block: ready %b%b expected 00", req0_ready, req1_ready); end
    aes_busy = 1'b0;
    #1;
    tests++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      fails++; $display("FAIL busy_release: ready %b%b expected 01", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(1, cyc);
    tests++;
    if (rsp1_data !== (D1 ^ MASK)) begin fails++; $display("FAIL busy_data: got %h expected %h", rsp1_data, D1 ^ MASK); end
    ack_port(1);
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_backpressure;
    test_timeout;
    test_midreset;
    test_aes_busy;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_core_arbiter.md
AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64: maximum number of WAIT cycles allowed for aes_done before the operation is aborted.
REQ-002 clk  input  1  single clock; all logic is on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has a block to encrypt.
REQ-005 req0_data  input  128  requester 0 input block.
REQ-006 req0_ready  output  1  requester 0 block accepted this cycle.
REQ-007 rsp0_valid  output  1  requester 0 result available.
REQ-008 rsp0_data  output  128  requester 0 result block.
REQ-009 rsp0_ack  input  1  requester 0 consumes the result.
REQ-010 req1_valid, req1_data, req1_ready, rsp1_valid, rsp1_data, rsp1_ack: same directions, widths and meanings as the requester 0 ports, for requester 1.
REQ-011 aes_start  output  1  one-cycle start pulse to the shared AES-256 core.
REQ-012 aes_in  output  128  block presented to the core; held stable from aes_start until aes_done.
REQ-013 aes_out  input  128  core result; valid when aes_done=1.
REQ-014 aes_done  input  1  core completion pulse.
REQ-015 aes_busy  input  1  core is occupied.
REQ-016 grant_id  output  1  index of the requester that owns the current operation.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 timeout_err  output  1  sticky flag: an operation timed out.

Function
REQ-019 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP; only one operation SHALL be outstanding at any time.
REQ-020 In IDLE, with aes_busy=0 and at least one reqN_valid high, the block SHALL accept one request: reqN_ready=1 combinationally for that cycle only, aes_in<=reqN_data, grant_id<=N, next state ISSUE.
REQ-021 Arbitration SHALL be round-robin: a lone requester always wins; if both are valid, the requester that was not last_grant wins; after reset last_grant=1, so requester 0 wins first.
REQ-022 While aes_busy=1 in IDLE, no request SHALL be accepted and both ready signals SHALL be 0; ready SHALL be 0 in every state other than IDLE.
REQ-023 ISSUE: aes_start=1 for exactly this cycle, wait counter cleared, next state WAIT.
REQ-024 WAIT: when aes_done=1, the block SHALL capture aes_out into rsp<grant_id>_data and go to RESP; otherwise the counter increments.
REQ-025 WAIT timeout: when the counter reaches TIMEOUT_CYC-1 with aes_done=0, the block SHALL set timeout_err=1, produce no response, leave last_grant unchanged, and return to IDLE.
REQ-026 RESP: rsp<grant_id>_valid=1 and held with data stable until rsp<grant_id>_ack=1; in the ack cycle the block SHALL set last_grant<=grant_id, drop valid on the next cycle, and return to IDLE.
REQ-027 An ack on the non-granted port, or an ack outside RESP, SHALL be ignored.
REQ-028 aes_done outside WAIT SHALL be ignored; it SHALL NOT alter any response data.
REQ-029 Latency: if a request is accepted at cycle T, aes_start is high at T+1; rsp_valid is high in the cycle after aes_done; the earliest next acceptance is in the cycle after the ack.
REQ-030 A request still valid while the arbiter is busy SHALL remain pending; the requester holds reqN_valid and reqN_data until it sees ready.
REQ-031 rspN_data SHALL retain its last captured value until the next completion for that port.

Reset
REQ-032 When rst=1 at a clock edge, the block SHALL set: state IDLE, aes_start 0, aes_in 0, rsp0/1_valid 0, rsp0/1_data 0, grant_id 0, busy 0, timeout_err 0, last_grant 1, counter 0.
REQ-033 Reset in any state SHALL abort the operation in flight with no response, and a later aes_done SHALL be ignored.
REQ-034 timeout_err SHALL be cleared only by rst.

Verification
REQ-035 Single request: req0_valid with req0_data=0 and a core model with 14-cycle latency returning 128'hAA..AA -> req0_ready at T, aes_start at T+1, rsp0_valid with 128'hAA..AA held until rsp0_ack, rsp1_valid stays 0.
REQ-036 Contention: both requests valid continuously from reset, acks given immediately -> grant order 0,1,0,1 and exactly one aes_start per operation.
REQ-037 Backpressure: rsp1_ack withheld 20 cycles -> rsp1_valid and rsp1_data stable, no new acceptance, aes_start stays 0.
REQ-038 Timeout: the core never asserts aes_done and TIMEOUT_CYC=64 -> timeout_err=1 after 64 WAIT cycles, FSM in IDLE, the next request is accepted normally, and timeout_err stays 1.
REQ-039 Mid-operation reset: rst asserted in WAIT, then a stray aes_done -> all outputs at reset values, no rsp_valid, requester 0 wins the next contention.
REQ-040 aes_busy=1 held in IDLE with both requests valid -> no ready until aes_busy=0.
